// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed BCD seven-segment driver. It accepts a frame
//               through a one-deep pending buffer and commits it only at a
//               frame boundary, so a frame is never shown half old and half
//               new. It also supports leading-zero blanking, whole-display
//               blinking and an error flag for non-BCD nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 3,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    bcd_err
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0]         c_presc_last = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         c_idx_last   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0]         c_blink_last = BW'(BLINK_FRAMES - 1);
  // Inactive output levels; also used as the polarity XOR mask.
  localparam logic [NUM_DIGITS-1:0] c_an_off     = {NUM_DIGITS{SEG_ACTIVE_LOW}};
  localparam logic [6:0]            c_seg_off    = {7{SEG_ACTIVE_LOW}};

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic                    r_pend_full;
  logic                    r_err;
  logic [BW-1:0]           r_blink_cnt;
  logic                    r_phase_on;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;

  logic                    w_tick;
  logic                    w_frame;
  logic [IW-1:0]           w_idx_nxt;
  logic                    w_xfer;
  logic                    w_commit;
  logic [4*NUM_DIGITS-1:0] w_disp_nxt;
  logic                    w_phase_nxt;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_bad;
  logic                    w_hi_zero;
  logic [NUM_DIGITS-1:0]   w_an_raw;
  logic [6:0]              w_seg_raw;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h3F;
      4'd1:    f_decode = 7'h06;
      4'd2:    f_decode = 7'h5B;
      4'd3:    f_decode = 7'h4F;
      4'd4:    f_decode = 7'h66;
      4'd5:    f_decode = 7'h6D;
      4'd6:    f_decode = 7'h7D;
      4'd7:    f_decode = 7'h07;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h6F;
      default: f_decode = 7'h40;
    endcase
  endfunction

  assign w_tick    = (r_presc == c_presc_last);
  assign w_frame   = w_tick && (r_idx == c_idx_last);
  assign w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + IW'(1);
  assign w_xfer    = load_valid && !r_pend_full;
  assign w_commit  = w_frame && r_pend_full;

  // The digit shown on a boundary edge already comes from the frame committed
  // on that same edge, and it follows the blink phase entered on that edge.
  assign w_disp_nxt  = w_commit ? r_pend : r_disp;
  assign w_phase_nxt = (w_frame && (r_blink_cnt == c_blink_last)) ? ~r_phase_on : r_phase_on;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign w_nib[k] = w_disp_nxt[4*k +: 4];
    assign w_bad[k] = (r_pend[4*k +: 4] > 4'd9);
  end

  // Build the pattern for the digit slot being entered.
  always_comb begin
    w_an_raw            = '0;
    w_an_raw[w_idx_nxt] = 1'b1;
    w_seg_raw           = f_decode(w_nib[w_idx_nxt]);
    w_hi_zero           = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(w_idx_nxt)) && (w_nib[k] != 4'd0)) begin
        w_hi_zero = 1'b0;
      end
    end
    if (blank_lz && (w_idx_nxt != '0) && w_hi_zero) begin
      w_seg_raw = 7'h00;
    end
    if (blink_en && !w_phase_nxt) begin
      w_an_raw  = '0;
      w_seg_raw = 7'h00;
    end
  end

  // Prescaler and digit index; the index moves once per prescaler wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_idx <= w_idx_nxt;
      end
    end
  end

  // Load handshake into the pending buffer, committed only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_disp      <= '0;
      r_err       <= 1'b0;
    end else if (w_commit) begin
      r_disp      <= r_pend;
      r_pend_full <= 1'b0;
      r_err       <= |w_bad;
    end else if (w_xfer) begin
      r_pend      <= bcd_in;
      r_pend_full <= 1'b1;
    end
  end

  // Blink phase runs on frame boundaries whether or not blinking is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else if (w_frame) begin
      r_blink_cnt <= (r_blink_cnt == c_blink_last) ? '0 : r_blink_cnt + BW'(1);
      r_phase_on  <= w_phase_nxt;
    end
  end

  // Registered outputs with polarity applied; they change only with the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= c_an_off;
      r_seg <= c_seg_off;
    end else if (w_tick) begin
      r_an  <= w_an_raw ^ c_an_off;
      r_seg <= w_seg_raw ^ c_seg_off;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign load_ready = ~r_pend_full;
  assign bcd_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver. A behavioural model
//               derives the expected outputs from the edge count since reset,
//               and it runs alongside table vectors and directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int ND = 3;
  localparam int SD = 4;
  localparam int BF = 2;

  logic            clk        = 1'b0;
  logic            rst_n      = 1'b0;
  logic            load_valid = 1'b0;
  logic            blank_lz   = 1'b0;
  logic            blink_en   = 1'b0;
  logic [4*ND-1:0] bcd_in     = '0;
  logic            load_ready;
  logic            bcd_err;
  logic [ND-1:0]   an;
  logic [6:0]      seg;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          e;
  logic [11:0] m_disp, m_pend;
  bit          m_full, m_err, m_xfer_evt, m_commit_evt;
  logic [2:0]  exp_an;
  logic [6:0]  exp_seg;
  logic [6:0]  dec [16];

  typedef struct {
    logic [11:0] val;
    bit          blz;
    logic [6:0]  s0, s1, s2;
    bit          err;
  } vec_t;

  vec_t vecs [8];

  seg7_scan_driver #(
    .NUM_DIGITS    (ND),
    .SCAN_DIV      (SD),
    .BLINK_FRAMES  (BF),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .bcd_in    (bcd_in),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .an        (an),
    .seg       (seg),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic reset_model();
    e = 0; m_disp = '0; m_pend = '0; m_full = 0; m_err = 0;
    m_xfer_evt = 0; m_commit_evt = 0; exp_an = '0; exp_seg = '0;
  endtask

  // One clock edge of the reference: edge e after release is a tick when
  // e is a multiple of SD; slot s = e/SD selects digit s%ND in frame s/ND.
  task automatic model_edge();
    int  s, idx, f, d;
    bit  tick, boundary, off;
    logic [3:0] nib;
    m_xfer_evt = 0; m_commit_evt = 0;
    e++;
    tick = (e % SD == 0);
    s = e / SD; idx = s % ND; f = s / ND;
    boundary = tick && (idx == 0);
    if (boundary && m_full) begin
      m_disp = m_pend; m_full = 0; m_commit_evt = 1; m_err = 0;
      for (int k = 0; k < ND; k++)
        if (((int'(m_disp) >> (4*k)) % 16) > 9) m_err = 1;
    end else if (load_valid && !m_full) begin
      m_pend = bcd_in; m_full = 1; m_xfer_evt = 1;
    end
    if (tick) begin
      d   = int'(m_disp);
      nib = 4'((d >> (4*idx)) % 16);
      off = blink_en && ((f / BF) % 2 == 1);
      if (off) begin
        exp_an = '0; exp_seg = '0;
      end else begin
        exp_an = 3'(1 << idx);
        if (blank_lz && idx > 0 && (d >> (4*idx)) == 0) exp_seg = 7'h00;
        else exp_seg = dec[nib];
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("load_ready", 32'(load_ready), 32'(!m_full));
    check("bcd_err", 32'(bcd_err), 32'(m_err));
  endtask

  task automatic load(input string name, input logic [11:0] v);
    int n = 0;
    bcd_in = v; load_valid = 1'b1;
    do begin cycle(); n++; end while (!m_xfer_evt && n < 100);
    check({name, "_xfer_timeout"}, 32'(m_xfer_evt), 32'd1);
    load_valid = 1'b0;
  endtask

  task automatic wait_commit(input string name);
    int n = 0;
    do begin cycle(); n++; end while (!m_commit_evt && n < 100);
    check({name, "_commit_timeout"}, 32'(m_commit_evt), 32'd1);
  endtask

  // Watch 12 consecutive cycles and record the segments shown per digit.
  task automatic capture_check(input string name, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2);
    logic [6:0] got [ND];
    bit         seen [ND];
    for (int k = 0; k < ND; k++) begin got[k] = '0; seen[k] = 0; end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cycle();
      for (int k = 0; k < ND; k++)
        if (an[k]) begin got[k] = seg; seen[k] = 1; end
    end
    check({name, "_d0"}, 32'({seen[0], got[0]}), 32'({1'b1, s0}));
    check({name, "_d1"}, 32'({seen[1], got[1]}), 32'({1'b1, s1}));
    check({name, "_d2"}, 32'({seen[2], got[2]}), 32'({1'b1, s2}));
  endtask

  initial begin
    int n;
    int offc;
    dec = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    vecs[0] = '{12'h159, 1'b0, 7'h6F, 7'h6D, 7'h06, 1'b0};
    vecs[1] = '{12'h005, 1'b1, 7'h6D, 7'h00, 7'h00, 1'b0};
    vecs[2] = '{12'h000, 1'b1, 7'h3F, 7'h00, 7'h00, 1'b0};
    vecs[3] = '{12'h050, 1'b1, 7'h3F, 7'h6D, 7'h00, 1'b0};
    vecs[4] = '{12'h800, 1'b1, 7'h3F, 7'h3F, 7'h7F, 1'b0};
    vecs[5] = '{12'h1A3, 1'b0, 7'h4F, 7'h40, 7'h06, 1'b1};
    vecs[6] = '{12'h123, 1'b0, 7'h4F, 7'h5B, 7'h06, 1'b0};
    vecs[7] = '{12'hF00, 1'b0, 7'h3F, 7'h3F, 7'h40, 1'b1};

    // Reset, then first tick lands SD cycles after release on digit 1
    reset_model();
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    for (int i = 1; i <= SD; i++) begin
      cycle();
      if (i == SD - 1) check("pre_tick_an", 32'(an), 32'd0);
    end
    check("first_tick_an", 32'(an), 32'h2);
    check("first_tick_seg", 32'(seg), 32'h3F);

    // Table vectors
    foreach (vecs[i]) begin
      blank_lz = vecs[i].blz;
      load($sformatf("vec%0d", i), vecs[i].val);
      wait_commit($sformatf("vec%0d", i));
      capture_check($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].s2);
      check($sformatf("vec%0d_err", i), 32'(bcd_err), 32'(vecs[i].err));
    end

    // Back-to-back loads: second one waits for the first commit
    blank_lz = 1'b0;
    bcd_in = 12'h123; load_valid = 1'b1;
    cycle();
    check("b2b_ready_low", 32'(load_ready), 32'd0);
    bcd_in = 12'h456;
    wait_commit("b2b_first");
    check("b2b_first_d0", 32'(seg), 32'h4F);
    n = 0;
    do begin cycle(); n++; end while (!m_xfer_evt && n < 100);
    check("b2b_second_xfer_timeout", 32'(m_xfer_evt), 32'd1);
    load_valid = 1'b0;
    check("b2b_second_ready_low", 32'(load_ready), 32'd0);
    wait_commit("b2b_second");
    capture_check("b2b_456", 7'h7D, 7'h6D, 7'h66);

    // Blink: half of each 48-cycle period is dark
    blink_en = 1'b1;
    repeat (SD) cycle();
    offc = 0;
    for (int i = 0; i < 96; i++) begin
      cycle();
      if (an == '0) offc++;
    end
    check("blink_off_cycles", 32'(offc), 32'd48);
    blink_en = 1'b0;
    repeat (SD) cycle();

    // Reset with pending full discards the pending frame
    load("rst_pre", 12'h777);
    cycle();
    rst_n = 1'b0;
    reset_model();
    #1;
    check("rst_an", 32'(an), 32'd0);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_err", 32'(bcd_err), 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (40) cycle();
    capture_check("post_rst", 7'h3F, 7'h3F, 7'h3F);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < ND; k++)
        bcd_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 79) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        reset_model();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
